dmem_timer_responder: RTL and testbench

//   Data-side memory responder for the single-cycle MIPS core: answers memwrite/memaddr/

---
 rtl/dmem_timer_responder.sv | 111 +++++++++++
 tb/tb_dmem_timer_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_timer_responder.sv
// Data-side memory responder: word RAM plus an optional memory-mapped timer.
// Define DMEM_TIMER_EN to build the timer and its register window; otherwise that window is unmapped.
module dmem_timer_responder #(
    parameter int unsigned RAM_WORDS = 64,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic        irq,
    output logic        err
);

    localparam int unsigned AW        = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS * 4);

    logic [31:0]   ram [RAM_WORDS];
    logic [AW-1:0] idx;
    logic          ram_hit;
    logic          mmio_hit;
    logic          aligned;
    logic          ram_we;
    logic          err_set;
    logic [1:0]    status;
    logic [1:0]    status_clr;
    logic          match_now;
    logic [31:0]   reg_rd;

    assign idx     = memaddr[AW+1:2];
    assign ram_hit = {1'b0, memaddr} < RAM_BYTES;
    assign aligned = (memaddr[1:0] == 2'b00);

    // A store arriving together with reset is discarded.
    assign ram_we  = memwrite & aligned & ram_hit & ~reset;
    assign err_set = memwrite & (~aligned | (~ram_hit & ~mmio_hit));

    always_ff @(posedge clk) begin
        if (ram_we) ram[idx] <= memwritedata;
    end

`ifdef DMEM_TIMER_EN
    logic [31:0] count;
    logic [31:0] cmp;
    logic [2:0]  ctrl;
    logic        reg_wr;
    logic [1:0]  sel;

    assign mmio_hit   = (memaddr[31:4] == MMIO_BASE[31:4]);
    assign sel        = memaddr[3:2];
    assign reg_wr     = memwrite & aligned & mmio_hit;
    assign match_now  = ctrl[0] & (count == cmp);
    assign status_clr = (reg_wr && sel == 2'd3) ? memwritedata[1:0] : 2'b00;
    assign irq        = status[0] & ctrl[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            cmp   <= '1;
            ctrl  <= '0;
        end else begin
            // Core write to COUNT overrides the increment/reload of the same cycle.
            if (reg_wr && sel == 2'd0)
                count <= memwritedata;
            else if (ctrl[0])
                count <= (match_now && ctrl[1]) ? '0 : count + 32'd1;
            if (reg_wr && sel == 2'd1) cmp  <= memwritedata;
            if (reg_wr && sel == 2'd2) ctrl <= memwritedata[2:0];
        end
    end

    always_comb begin
        reg_rd = '0;
        case (sel)
            2'd0:    reg_rd = count;
            2'd1:    reg_rd = cmp;
            2'd2:    reg_rd = {29'd0, ctrl};
            default: reg_rd = {30'd0, status};
        endcase
    end
`else
    assign mmio_hit   = 1'b0;
    assign match_now  = 1'b0;
    assign status_clr = 2'b00;
    assign reg_rd     = '0;
    assign irq        = 1'b0;
`endif

    // Hardware set wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            status <= '0;
        else
            status <= (status & ~status_clr) | {err_set, match_now};
    end

    assign err = status[1];

    always_comb begin
        memreaddata = '0;
        if (!reset) begin
            if (ram_hit)
                memreaddata = ram[idx];
            else if (mmio_hit)
                memreaddata = reg_rd;
        end
    end

endmodule

// File: tb/tb_dmem_timer_responder.sv
// Scoreboard bench for dmem_timer_responder: directed scenarios plus random accesses
// checked against a behavioural model; follows DMEM_TIMER_EN if defined.
module tb_dmem_timer_responder;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef DMEM_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [31:0] memreaddata;
    logic        irq;
    logic        err;

    dmem_timer_responder #(.RAM_WORDS(64), .MMIO_BASE(BASE)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .memaddr(memaddr),
        .memwritedata(memwritedata), .memreaddata(memreaddata), .irq(irq), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rd;
        bit          chk_rd;
        logic        irq;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    bit   in_reset = 1'b1;

    // Reference model state
    bit [31:0] m_count, m_cmp;
    bit [2:0]  m_ctrl;
    bit        m_match, m_err;
    bit [31:0] m_ram [64];
    bit        m_valid [64];

    task automatic chk(input string nm, input logic [31:0] addr,
                       input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s addr=%h got=%h want=%h t=%0t", nm, addr, act, want, $time);
        end
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return TIMER && ((a >> 4) == (BASE >> 4));
    endfunction

    function automatic exp_t expect_for(input logic [31:0] a);
        exp_t e;
        int unsigned w;
        e.addr = a; e.rd = 32'd0; e.chk_rd = 1'b1;
        w = a / 4;
        if (a < 32'd256) begin
            e.rd = m_ram[w % 64]; e.chk_rd = m_valid[w % 64];
        end else if (in_window(a)) begin
            case (w % 4)
                0: e.rd = m_count;
                1: e.rd = m_cmp;
                2: e.rd = 32'(m_ctrl);
                default: e.rd = 32'(m_err) * 2 + 32'(m_match);
            endcase
        end
        e.irq = TIMER && m_match && m_ctrl[2];
        e.err = m_err;
        return e;
    endfunction

    task automatic model_step(input bit we, input logic [31:0] a, input logic [31:0] d);
        bit in_ram, in_mmio, ok, hit;
        bit [31:0] next;
        int unsigned r;
        in_ram  = a < 32'd256;
        in_mmio = in_window(a);
        ok      = (a % 4 == 0) && (in_ram || in_mmio);
        r       = (a / 4) % 4;
        hit     = TIMER && m_ctrl[0] && (m_count == m_cmp);
        next    = m_count;
        if (TIMER && m_ctrl[0]) next = (hit && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
        if (we && ok && in_mmio && r == 3) begin
            if (d[0]) m_match = 1'b0;
            if (d[1]) m_err = 1'b0;
        end
        if (hit) m_match = 1'b1;
        if (we && !ok) m_err = 1'b1;
        if (we && ok && in_ram) begin
            m_ram[(a / 4) % 64] = d; m_valid[(a / 4) % 64] = 1'b1;
        end
        if (we && ok && in_mmio) begin
            if (r == 0) next = d;
            if (r == 1) m_cmp = d;
            if (r == 2) m_ctrl = d[2:0];
        end
        m_count = next;
    endtask

    task automatic model_reset();
        m_count = 32'd0; m_cmp = 32'hFFFF_FFFF; m_ctrl = 3'd0; m_match = 1'b0; m_err = 1'b0;
    endtask

    task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] d);
        memwrite = we; memaddr = a; memwritedata = d;
        sbq.push_back(expect_for(a));
        model_step(we, a, d);
        @(posedge clk); #1;
    endtask

    task automatic rnd_cyc();
        logic [31:0] a, d;
        bit we;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: a = 32'($urandom_range(0, 63)) << 2;
            4:          a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
            5, 6, 7:    a = BASE | (32'($urandom_range(0, 3)) << 2);
            8:          a = BASE | 32'($urandom_range(1, 15));
            default:    a = 32'h100 + 32'($urandom_range(0, 32'hFFFF));
        endcase
        we = ($urandom_range(0, 2) == 0);
        d  = $urandom;
        if (a[31:4] == BASE[31:4]) begin
            case (a[3:2])
                2'd0: d = 32'($urandom_range(0, 12));
                2'd1: d = 32'($urandom_range(0, 12));
                2'd2: d = 32'($urandom_range(0, 7));
                default: d = 32'($urandom_range(0, 3));
            endcase
        end
        cyc(we, a, d);
    endtask

    always @(negedge clk) begin
        if (!in_reset && sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            if (e.chk_rd) chk("rdata", e.addr, memreaddata, e.rd);
            chk("irq", e.addr, 32'(irq), 32'(e.irq));
            chk("err", e.addr, 32'(err), 32'(e.err));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; memwrite = 1'b0; memaddr = '0; memwritedata = '0;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd", memaddr, memreaddata, 32'd0);
        chk("reset_irq", memaddr, 32'(irq), 32'd0);
        chk("reset_err", memaddr, 32'(err), 32'd0);
        reset = 1'b0; in_reset = 1'b0;

        // RAM store then load, neighbour untouched
        cyc(1, 32'hC, 32'hCAFE_0001);
        cyc(1, 32'h8, 32'h1234_5678);
        cyc(0, 32'h8, 0);
        cyc(0, 32'hC, 0);
        for (int unsigned r = 0; r < 4; r++) cyc(0, BASE | (r << 2), 0);

        // Compare match with irq, then W1C
        cyc(1, BASE + 4, 5);
        cyc(1, BASE + 8, 5);
        for (int i = 0; i < 9; i++) cyc(0, BASE, 0);
        cyc(0, BASE + 12, 0);
        cyc(1, BASE + 12, 1);
        cyc(0, BASE + 12, 0);

        // Autoreload
        cyc(1, BASE + 8, 0);
        cyc(1, BASE, 0);
        cyc(1, BASE + 4, 3);
        cyc(1, BASE + 12, 3);
        cyc(1, BASE + 8, 3);
        for (int i = 0; i < 8; i++) cyc(0, BASE, 0);
        cyc(0, BASE + 12, 0);

        // Wrap, COUNT write priority, match vs W1C
        cyc(1, BASE + 8, 0);
        cyc(1, BASE, 32'hFFFF_FFFF);
        cyc(1, BASE + 8, 1);
        cyc(0, BASE, 0);
        cyc(1, BASE, 32'h10);
        cyc(0, BASE, 0);
        cyc(1, BASE + 8, 0);
        cyc(1, BASE + 12, 3);
        cyc(1, BASE, 0);
        cyc(1, BASE + 4, 2);
        cyc(1, BASE + 8, 1);
        cyc(0, BASE, 0);
        cyc(0, BASE, 0);
        cyc(1, BASE + 12, 1);
        cyc(0, BASE + 12, 0);

        // Access errors
        cyc(1, 32'h4002, 32'hBAD0_0001);
        cyc(1, 32'h0001_0000, 32'hBAD0_0002);
        cyc(1, 32'h9, 32'hBAD0_0003);
        cyc(0, 32'h8, 0);
        cyc(0, 32'h0001_0000, 0);
        cyc(0, 32'h9, 0);
        cyc(1, BASE + 12, 2);
        cyc(0, BASE + 12, 0);

        for (int i = 0; i < 400; i++) rnd_cyc();

        // Reset mid-count with a store pending
        cyc(1, 32'h10, 32'h55AA_55AA);
        cyc(1, BASE + 4, 3);
        cyc(1, BASE + 8, 7);
        cyc(1, 32'h3, 0);
        cyc(0, BASE, 0);
        memwrite = 1'b1; memaddr = 32'h10; memwritedata = 32'hDEAD_BEEF;
        in_reset = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("rst_rd", memaddr, memreaddata, 32'd0);
        chk("rst_irq", memaddr, 32'(irq), 32'd0);
        chk("rst_err", memaddr, 32'(err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; memwrite = 1'b0;
        model_reset();
        in_reset = 1'b0;
        cyc(0, 32'h10, 0);
        for (int unsigned r = 0; r < 4; r++) cyc(0, BASE | (r << 2), 0);

        for (int i = 0; i < 200; i++) rnd_cyc();

        memwrite = 1'b0;
        repeat (2) @(posedge clk);
        if (sbq.size() != 0) begin
            n_vec++; n_fail++;
            $display("FAIL scoreboard_drain left=%0d want=0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
